data_mem_bridge: RTL and testbench

//   Data-side memory/MMIO slave sitting directly downstream of the CPU load/store port.

---
 rtl/data_mem_bridge_if.sv | 27 ++
 rtl/data_mem_bridge.sv | 123 ++++++++++++
 tb/tb_data_mem_bridge.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/data_mem_bridge_if.sv
// data_mem_bridge_if: CPU load/store port plus LED and TX byte stream.
// master = CPU/consumer side, slave = bridge side.
interface data_mem_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              cpu_write;
  logic              cpu_read;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic [7:0]        led;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              bus_err;

  modport master (
    output cpu_write, cpu_read, cpu_address, cpu_wdata, tx_ready,
    input  cpu_rdata, led, tx_valid, tx_data, bus_err
  );

  modport slave (
    input  cpu_write, cpu_read, cpu_address, cpu_wdata, tx_ready,
    output cpu_rdata, led, tx_valid, tx_data, bus_err
  );
endinterface

// File: rtl/data_mem_bridge.sv
// data_mem_bridge: word RAM + MMIO (LED, cycle counter, TX queue) slave.
// Ports: clk, rst (sync active-low), bus (slave: CPU req/rdata, led, tx stream, bus_err).
module data_mem_bridge #(
  parameter int              DATA_W    = 32,
  parameter int              ADDR_W    = 32,
  parameter int              RAM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int              TXQ_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  data_mem_bridge_if.slave bus
);
  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int PW     = $clog2(TXQ_DEPTH);
  localparam int CW     = PW + 1;

  logic [DATA_W-1:0] ram_mem [RAM_DEPTH];
  logic [7:0]        txq_mem [TXQ_DEPTH];

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]        led_q, led_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]     wp_q, wp_d;
  logic [PW-1:0]     rp_q, rp_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic              wr, rd;
  logic [ADDR_W-1:0] off;
  logic              in_ram, in_mmio, unmapped;
  logic [RAM_AW-1:0] ram_idx;
  logic              sel_led, sel_tx, sel_st, sel_cyc;
  logic              full, empty, push, pop, push_ok;
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    wr       = bus.cpu_write;
    rd       = bus.cpu_read & ~bus.cpu_write;
    off      = bus.cpu_address - MMIO_BASE;
    in_ram   = bus.cpu_address < ADDR_W'(RAM_DEPTH);
    in_mmio  = (bus.cpu_address >= MMIO_BASE) && (off < ADDR_W'(4));
    unmapped = ~in_ram & ~in_mmio;
    ram_idx  = bus.cpu_address[RAM_AW-1:0];
    sel_led  = in_mmio && (off[1:0] == 2'd0);
    sel_tx   = in_mmio && (off[1:0] == 2'd1);
    sel_st   = in_mmio && (off[1:0] == 2'd2);
    sel_cyc  = in_mmio && (off[1:0] == 2'd3);
  end

  // Pop only sees the registered head, so a fresh push is never popped.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(TXQ_DEPTH));
    pop     = ~empty & bus.tx_ready;
    push    = wr & sel_tx;
    push_ok = push & (~full | pop);
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      in_ram:  rd_val = ram_mem[ram_idx];
      sel_led: rd_val = DATA_W'(led_q);
      sel_st:  rd_val = DATA_W'({ovf_q, full, empty, count_q});
      sel_cyc: rd_val = cnt_q;
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    rdata_d = rd ? rd_val : rdata_q;
    led_d   = (wr & sel_led) ? bus.cpu_wdata[7:0] : led_q;
    cnt_d   = (wr & sel_cyc) ? bus.cpu_wdata : cnt_q + 1'b1;
    wp_d    = push_ok ? wp_q + 1'b1 : wp_q;
    rp_d    = pop ? rp_q + 1'b1 : rp_q;
    count_d = count_q;
    if (push_ok & ~pop) count_d = count_q + 1'b1;
    if (~push_ok & pop) count_d = count_q - 1'b1;
    ovf_d   = ovf_q;
    if (wr & sel_st) ovf_d = 1'b0;
    if (push & full & ~pop) ovf_d = 1'b1;
    err_d   = err_q | ((wr | rd) & unmapped);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
      led_q   <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Storage arrays carry no reset; reset only blocks writes.
  always_ff @(posedge clk) begin
    if (rst && wr && in_ram) ram_mem[ram_idx] <= bus.cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst && push_ok) txq_mem[wp_q] <= bus.cpu_wdata[7:0];
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.led       = led_q;
  assign bus.tx_valid  = ~empty;
  assign bus.tx_data   = empty ? 8'h00 : txq_mem[rp_q];
  assign bus.bus_err   = err_q;
endmodule

// File: tb/tb_data_mem_bridge.sv
// tb_data_mem_bridge: directed checks of RAM, MMIO, TX queue and counter.
// Drives #1 after posedge, samples #1 after posedge.
module tb_data_mem_bridge;
  localparam logic [31:0] BASE   = 32'hFFFF_0000;
  localparam logic [31:0] A_LED  = BASE;
  localparam logic [31:0] A_TX   = BASE + 1;
  localparam logic [31:0] A_ST   = BASE + 2;
  localparam logic [31:0] A_CYC  = BASE + 3;

  logic clk;
  logic rst;
  int   errs;
  int   checks;

  data_mem_bridge_if #(.DATA_W(32), .ADDR_W(32)) bus_if ();

  data_mem_bridge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_if.cpu_write   = 1'b1;
    bus_if.cpu_address = a;
    bus_if.cpu_wdata   = d;
    tick();
    bus_if.cpu_write   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    bus_if.cpu_read    = 1'b1;
    bus_if.cpu_address = a;
    tick();
    bus_if.cpu_read    = 1'b0;
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    rst                = 1'b0;
    bus_if.cpu_write   = 1'b1;
    bus_if.cpu_read    = 1'b0;
    bus_if.cpu_address = A_LED;
    bus_if.cpu_wdata   = 32'hFF;
    bus_if.tx_ready    = 1'b0;
    tick();
    tick();
    chk("rst_rdata", bus_if.cpu_rdata, 32'h0);
    chk("rst_led", 32'(bus_if.led), 32'h0);
    chk("rst_txv", 32'(bus_if.tx_valid), 32'h0);
    chk("rst_txd", 32'(bus_if.tx_data), 32'h0);
    chk("rst_err", 32'(bus_if.bus_err), 32'h0);
    rst              = 1'b1;
    bus_if.cpu_write = 1'b0;
    rd(A_ST);
    chk("rst_status", bus_if.cpu_rdata, 32'h08);

    wr(32'd5, 32'hDEAD_BEEF);
    wr(32'd6, 32'h1234_5678);
    rd(32'd6);
    chk("ram6", bus_if.cpu_rdata, 32'h1234_5678);
    rd(32'd5);
    chk("ram5", bus_if.cpu_rdata, 32'hDEAD_BEEF);
    chk("err_clean", 32'(bus_if.bus_err), 32'h0);
    rd(32'd5 + 32'd1024);
    chk("unmap_rd", bus_if.cpu_rdata, 32'h0);
    chk("unmap_err", 32'(bus_if.bus_err), 32'h1);
    rd(32'd5);

    bus_if.cpu_read = 1'b1;
    wr(A_LED, 32'hA5);
    bus_if.cpu_read = 1'b0;
    chk("led_wr", 32'(bus_if.led), 32'hA5);
    chk("wr_wins", bus_if.cpu_rdata, 32'hDEAD_BEEF);
    rd(A_LED);
    chk("led_rd", bus_if.cpu_rdata, 32'hA5);

    for (int i = 0; i < 5; i++) wr(A_TX, 32'h11 + 32'(i));
    chk("txq_valid", 32'(bus_if.tx_valid), 32'h1);
    rd(A_ST);
    chk("st_full_ovf", bus_if.cpu_rdata, 32'h34);
    bus_if.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain1", 32'(bus_if.tx_data), 32'h11 + 32'(i));
      tick();
    end
    chk("drain1_end", 32'(bus_if.tx_valid), 32'h0);
    bus_if.tx_ready = 1'b0;
    wr(A_ST, 32'h0);
    rd(A_ST);
    chk("ovf_clr", bus_if.cpu_rdata, 32'h08);

    for (int i = 0; i < 4; i++) wr(A_TX, 32'hA1 + 32'(i));
    bus_if.tx_ready = 1'b1;
    wr(A_TX, 32'hB5);
    bus_if.tx_ready = 1'b0;
    rd(A_ST);
    chk("st_pushpop", bus_if.cpu_rdata, 32'h14);
    bus_if.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("drain2", 32'(bus_if.tx_data), 32'hA2 + 32'(i));
      tick();
    end
    chk("drain2_last", 32'(bus_if.tx_data), 32'hB5);
    tick();
    chk("drain2_end", 32'(bus_if.tx_valid), 32'h0);

    wr(A_TX, 32'h77);
    chk("push_nopop", 32'(bus_if.tx_valid), 32'h1);
    chk("push_data", 32'(bus_if.tx_data), 32'h77);
    tick();
    chk("push_drained", 32'(bus_if.tx_valid), 32'h0);
    bus_if.tx_ready = 1'b0;

    wr(A_CYC, 32'hFFFF_FFFE);
    tick();
    rd(A_CYC);
    chk("cyc_max", bus_if.cpu_rdata, 32'hFFFF_FFFF);
    rd(A_CYC);
    chk("cyc_wrap", bus_if.cpu_rdata, 32'h0);
    chk("err_sticky", 32'(bus_if.bus_err), 32'h1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
